// File: rtl/fsm_control_unit.sv
// Multi-cycle control unit: accepts one instruction over valid/ready, latches it into IR,
// then steps DECODE -> EXECUTE -> WRITEBACK driving ALU/register-file/immediate controls.
module fsm_control_unit #(
  parameter int INSTR_W = 16,
  parameter int REG_AW  = 3,
  parameter int CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [INSTR_W-1:0]          instr,
  input  logic                        instr_valid,
  output logic                        instr_ready,
  output logic                        alu_en,
  output logic [2:0]                  alu_control,
  output logic                        reg_write_en,
  output logic                        reg_write_data_sel,
  output logic [REG_AW-1:0]           dest_reg_sel,
  output logic [REG_AW-1:0]           src_reg1_sel,
  output logic [REG_AW-1:0]           src_reg2_sel,
  output logic [INSTR_W-3-REG_AW-1:0] imm_out,
  output logic                        done,
  output logic                        illegal,
  output logic                        halted,
  output logic [CNT_W-1:0]            retired_cnt,
  output logic [2:0]                  state_dbg
);

  // Handshake: an instruction transfers on a rising edge where instr_valid && instr_ready.
  // instr_ready is high only in IDLE; a held instr_valid is ignored until IDLE is re-entered.

  localparam int IMM_W = INSTR_W - 3 - REG_AW;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_NOT  = 3'b100;
  localparam logic [2:0] OP_LDI  = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_HALT      = 3'd4
  } state_t;

  state_t             state;
  logic [INSTR_W-1:0] ir;
  logic [2:0]         opcode;
  logic [REG_AW-1:0]  f_dest;
  logic [REG_AW-1:0]  f_src1;
  logic [REG_AW-1:0]  f_src2;
  logic               in_flight;

  assign opcode    = ir[INSTR_W-1 -: 3];
  assign f_dest    = ir[INSTR_W-4 -: REG_AW];
  assign f_src1    = ir[INSTR_W-4-REG_AW -: REG_AW];
  assign f_src2    = ir[INSTR_W-4-2*REG_AW -: REG_AW];
  assign in_flight = (state == S_DECODE) || (state == S_EXECUTE) || (state == S_WRITEBACK);

  assign instr_ready = (state == S_IDLE);
  assign state_dbg   = state;

  function automatic logic [2:0] alu_op(input logic [2:0] op);
    case (op)
      OP_ADD:  alu_op = 3'b000;
      OP_SUB:  alu_op = 3'b001;
      OP_AND:  alu_op = 3'b010;
      OP_OR:   alu_op = 3'b011;
      OP_NOT:  alu_op = 3'b100;
      OP_XOR:  alu_op = 3'b101;
      default: alu_op = 3'b000;
    endcase
  endfunction

  // Datapath selects come straight from IR while an instruction is in flight, zero otherwise.
  always_comb begin
    alu_control        = 3'b000;
    reg_write_data_sel = 1'b0;
    dest_reg_sel       = '0;
    src_reg1_sel       = '0;
    src_reg2_sel       = '0;
    imm_out            = '0;
    if (in_flight) begin
      alu_control        = alu_op(opcode);
      reg_write_data_sel = (opcode == OP_LDI);
      dest_reg_sel       = f_dest;
      src_reg1_sel       = f_src1;
      src_reg2_sel       = (opcode == OP_NOT) ? '0 : f_src2;
      imm_out            = ir[IMM_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      ir           <= '0;
      retired_cnt  <= '0;
      alu_en       <= 1'b0;
      reg_write_en <= 1'b0;
      done         <= 1'b0;
      illegal      <= 1'b0;
      halted       <= 1'b0;
    end else begin
      alu_en       <= 1'b0;
      reg_write_en <= 1'b0;
      done         <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            ir    <= instr;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (opcode == OP_HALT) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            state  <= S_EXECUTE;
            alu_en <= (opcode != OP_LDI);
            // NOT with a non-zero reserved src2 field is flagged but still executed.
            if ((opcode == OP_NOT) && (f_src2 != '0))
              illegal <= 1'b1;
          end
        end
        S_EXECUTE: begin
          state        <= S_WRITEBACK;
          reg_write_en <= 1'b1;
          done         <= 1'b1;
          retired_cnt  <= retired_cnt + CNT_W'(1);
        end
        S_WRITEBACK: state <= S_IDLE;
        S_HALT:      state <= S_HALT;
        default:     state <= S_IDLE;
      endcase
    end
  end

endmodule
